// File: rtl/usb_tx_sequencer_if.sv
// Signal bundle between the USB TX sequencer and its control registers, TX data buffer and serializer.
// The master modport is the sequencer's view; the slave modport is the surrounding environment.
interface usb_tx_sequencer_if #(
  parameter int MAX_BYTES = 64
);
  localparam int CW = $clog2(MAX_BYTES + 1);

  logic          tx_start;
  logic [2:0]    tx_packet;
  logic          tx_abort;
  logic [CW-1:0] buffer_occupancy;
  logic [7:0]    tx_packet_data;
  logic          get_tx_packet_data;
  logic [7:0]    byte_out;
  logic          byte_valid;
  logic          byte_ready;
  logic          eop_req;
  logic          eop_done;
  logic          tx_busy;
  logic          tx_done;
  logic          tx_error;

  modport master (
    input  tx_start, tx_packet, tx_abort, buffer_occupancy, tx_packet_data, byte_ready, eop_done,
    output get_tx_packet_data, byte_out, byte_valid, eop_req, tx_busy, tx_done, tx_error
  );

  modport slave (
    output tx_start, tx_packet, tx_abort, buffer_occupancy, tx_packet_data, byte_ready, eop_done,
    input  get_tx_packet_data, byte_out, byte_valid, eop_req, tx_busy, tx_done, tx_error
  );
endinterface

// File: rtl/usb_tx_sequencer.sv
// USB full-speed TX packet sequencer: SYNC, PID, payload, optional CRC16, then EOP request.
// Define USB_TX_HW_CRC_EN to append a hardware CRC16; otherwise the payload is sent verbatim.
module usb_tx_sequencer #(
  parameter int MAX_BYTES = 64
) (
  input  logic               clk,
  input  logic               rst,
  usb_tx_sequencer_if.master tx_if
);
  localparam int CW = $clog2(MAX_BYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_EOP, S_DONE
  } state_e;

  state_e        r_state, w_state_nxt;
  logic [2:0]    r_pkt, w_pkt_nxt;
  logic [CW-1:0] r_count, w_count_nxt;
  logic          r_tx_error, w_tx_error_nxt;
  logic [7:0]    w_byte_out;
  logic          w_byte_valid;
  logic          w_accept;
  logic          w_start_ok;
  logic          w_is_data;
  logic [3:0]    w_pid;
  state_e        w_after_data;

`ifdef USB_TX_HW_CRC_EN
  logic [15:0] r_crc, w_crc_nxt;

  // Bit-reflected CRC16 (poly 0x8005), data consumed LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  assign w_after_data = S_CRC_LO;
`else
  assign w_after_data = S_EOP;
`endif

  function automatic logic [3:0] pid_of(input logic [2:0] code);
    case (code)
      3'd1:    return 4'h3;
      3'd2:    return 4'hB;
      3'd3:    return 4'h2;
      3'd4:    return 4'hA;
      3'd5:    return 4'hE;
      default: return 4'h0;
    endcase
  endfunction

  assign w_pid        = pid_of(r_pkt);
  assign w_is_data    = (r_pkt == 3'd1) || (r_pkt == 3'd2);
  assign w_start_ok   = (tx_if.tx_packet >= 3'd1) && (tx_if.tx_packet <= 3'd5);
  assign w_byte_valid = (r_state == S_SYNC) || (r_state == S_PID) || (r_state == S_DATA) ||
                        (r_state == S_CRC_LO) || (r_state == S_CRC_HI);
  assign w_accept     = w_byte_valid && tx_if.byte_ready;

  assign tx_if.byte_valid         = w_byte_valid;
  assign tx_if.byte_out           = w_byte_out;
  assign tx_if.get_tx_packet_data = (r_state == S_DATA) && w_accept;
  assign tx_if.eop_req            = (r_state == S_EOP);
  assign tx_if.tx_busy            = (r_state != S_IDLE);
  assign tx_if.tx_done            = (r_state == S_DONE);
  assign tx_if.tx_error           = r_tx_error;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (rst) begin
      r_state    <= S_IDLE;
      r_pkt      <= 3'd0;
      r_count    <= '0;
      r_tx_error <= 1'b0;
`ifdef USB_TX_HW_CRC_EN
      r_crc      <= 16'hFFFF;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_pkt      <= w_pkt_nxt;
      r_count    <= w_count_nxt;
      r_tx_error <= w_tx_error_nxt;
`ifdef USB_TX_HW_CRC_EN
      r_crc      <= w_crc_nxt;
`endif
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    w_state_nxt    = r_state;
    w_pkt_nxt      = r_pkt;
    w_count_nxt    = r_count;
    w_tx_error_nxt = 1'b0;
    w_byte_out     = 8'h00;
`ifdef USB_TX_HW_CRC_EN
    w_crc_nxt      = r_crc;
`endif

    case (r_state)
      S_IDLE: begin
        // A simultaneous abort cancels the start silently.
        if (tx_if.tx_start && !tx_if.tx_abort) begin
          if (w_start_ok) begin
            w_pkt_nxt   = tx_if.tx_packet;
            w_count_nxt = ((tx_if.tx_packet == 3'd1) || (tx_if.tx_packet == 3'd2)) ?
                          tx_if.buffer_occupancy : '0;
`ifdef USB_TX_HW_CRC_EN
            w_crc_nxt   = 16'hFFFF;
`endif
            w_state_nxt = S_SYNC;
          end else begin
            w_tx_error_nxt = 1'b1;
          end
        end
      end
      S_SYNC: begin
        w_byte_out = 8'h80;
        if (w_accept) w_state_nxt = S_PID;
      end
      S_PID: begin
        w_byte_out = {~w_pid, w_pid};
        if (w_accept) begin
          if (!w_is_data)           w_state_nxt = S_EOP;
          else if (r_count == '0)   w_state_nxt = w_after_data;
          else                      w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        w_byte_out = tx_if.tx_packet_data;
        if (w_accept) begin
          w_count_nxt = r_count - CW'(1);
`ifdef USB_TX_HW_CRC_EN
          w_crc_nxt   = crc16_byte(r_crc, tx_if.tx_packet_data);
`endif
          if (r_count == CW'(1)) w_state_nxt = w_after_data;
        end
      end
`ifdef USB_TX_HW_CRC_EN
      S_CRC_LO: begin
        w_byte_out = ~r_crc[7:0];
        if (w_accept) w_state_nxt = S_CRC_HI;
      end
      S_CRC_HI: begin
        w_byte_out = ~r_crc[15:8];
        if (w_accept) w_state_nxt = S_EOP;
      end
`endif
      S_EOP: begin
        if (tx_if.eop_done) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Commands arriving mid-packet never disturb it; abort overrides everything else.
    if (r_state != S_IDLE) begin
      if (tx_if.tx_start) w_tx_error_nxt = 1'b1;
      if (tx_if.tx_abort) begin
        w_state_nxt    = S_IDLE;
        w_tx_error_nxt = 1'b1;
      end
    end
  end
endmodule

// File: doc/usb_tx_sequencer.md
# usb_tx_sequencer

Packet-level controller for the USB full-speed transmit path. It sits between the AHB-Lite TX register file / TX data buffer and the bit-level serializer (NRZI + bit-stuff + D+/D- drive). On a software packet command it produces the byte sequence SYNC, PID, payload, CRC16 and an EOP request, popping the data buffer and handshaking each byte into the serializer.

## Interface
Parameters:
- MAX_BYTES, default 64: TX data buffer depth; sets CW = $clog2(MAX_BYTES+1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- tx_start  in  1  one-cycle command pulse from control register write.
- tx_packet  in  3  packet code sampled with tx_start: 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL; 0/6/7 invalid.
- tx_abort  in  1  flush/abort pulse from flush register write.
- buffer_occupancy  in  CW  bytes currently in TX data buffer.
- tx_packet_data  in  8  head byte of TX data buffer (show-ahead).
- get_tx_packet_data  out  1  pop strobe to TX data buffer.
- byte_out  out  8  byte to serializer, LSB transmitted first.
- byte_valid  out  1  byte_out valid.
- byte_ready  in  1  serializer accepts byte when byte_valid & byte_ready.
- eop_req  out  1  level; serializer drives EOP after last byte drains.
- eop_done  in  1  one-cycle pulse when EOP and idle J complete.
- tx_busy  out  1  high in any state except IDLE.
- tx_done  out  1  one-cycle pulse on packet completion.
- tx_error  out  1  one-cycle pulse on rejected command or abort.

## Operation
- States: IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP, DONE.
- IDLE: on tx_start with valid code latch code and count = buffer_occupancy for DATA0/DATA1, 0 for handshakes; CRC register = 16'hFFFF; go SYNC. Invalid code: stay IDLE, pulse tx_error.
- SYNC: byte_out = 8'h80; on accept go PID.
- PID: byte_out = {~pid, pid}, pid = DATA0 4'h3 (8'hC3), DATA1 4'hB (8'h4B), ACK 4'h2 (8'hD2), NAK 4'hA (8'h5A), STALL 4'hE (8'h1E). On accept: handshake -> EOP; data with count 0 -> CRC_LO; else DATA.
- DATA: byte_out = tx_packet_data; get_tx_packet_data = byte_valid & byte_ready (combinational, same cycle as accept); on accept CRC updated with byte, count decremented; count reaching 0 -> CRC_LO.
- CRC16: polynomial 0x8005, bit-reflected (shift right, XOR 16'hA001), init 16'hFFFF, data LSB first; transmitted value = ~crc, low byte in CRC_LO, high byte in CRC_HI; CRC_HI accept -> EOP.
- EOP: byte_valid low, eop_req high until eop_done; then DONE.
- DONE: tx_done pulse, return to IDLE in one cycle.
- tx_start while tx_busy: ignored, tx_error pulse, running packet unaffected.
- tx_abort in any non-IDLE state: next edge -> IDLE, byte_valid/eop_req drop, no tx_done, tx_error pulse; no further pops. tx_abort in IDLE: no effect. tx_abort and tx_start in same IDLE cycle: abort wins, start dropped, no error.
- eop_done outside EOP: ignored. byte_ready held low: sequencer waits indefinitely.
- Occupancy changes after latch do not affect count.

## Timing
- Reset: state IDLE, byte_valid 0, byte_out 8'h00, get_tx_packet_data 0, eop_req 0, tx_busy 0, tx_done 0, tx_error 0, count 0, CRC 16'hFFFF.
- tx_start sampled at edge N -> byte_valid = 1 with 8'h80 from cycle N+1.
- byte_valid stays high across consecutive accepts; next byte presented cycle after accept edge, no bubble.
- Payload latency: one byte per accepted cycle; total byte count = 2 + count + 2 (data) or 2 (handshake).
- tx_done asserted cycle after eop_done sampled; tx_busy low in that same DONE-exit cycle +1.

## Configuration
- USB_TX_HW_CRC_EN defined: CRC_LO/CRC_HI states and CRC register present, CRC16 appended as above.
- Undefined: no CRC logic; DATA with count 0 goes directly to EOP; payload sent verbatim (software places CRC bytes in buffer); data packet length = 2 + count.

## Test plan
- Reset mid-DATA with byte_ready high -> all outputs at reset values immediately, tx_busy 0.
- ACK: tx_packet 3, tx_start, byte_ready 1 -> bytes 80, D2, eop_req; eop_done -> tx_done, 0 pops.
- DATA0 ZLP (occupancy 0), CRC enabled -> bytes 80, C3, 00, 00, then eop_req.
- DATA1, buffer 00 01 02 03, byte_ready toggling every other cycle -> 80, 4B, 00, 01, 02, 03, CRC bytes matching reflected-0x8005 model, exactly 4 pops, each coincident with an accept.
- tx_packet 6 in IDLE -> tx_error pulse, tx_busy stays 0; tx_start during DATA -> tx_error, packet completes unchanged.
- tx_abort after 2 payload bytes of 10 -> IDLE next edge, tx_error pulse, no tx_done, exactly 2 pops.
